// File: rtl/bram_pkg.sv
// Shared types and defaults for the block-RAM read streamer.
package bram_pkg;

    localparam int unsigned DefDwidth = 32;
    localparam int unsigned DefAwidth = 32;
    localparam int unsigned DefLwidth = 16;

    // Output buffer depth; the read issue rule is sized against this.
    localparam int unsigned FifoDepth = 2;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry synchronous FIFO with same-cycle push and pop; slot0 is always the head.
module stream_fifo2
    import bram_pkg::*;
#(
    parameter int unsigned DWIDTH = DefDwidth
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DWIDTH-1:0] head,
    output logic              empty
);

    logic [DWIDTH-1:0] slot0_q, slot0_d;
    logic [DWIDTH-1:0] slot1_q, slot1_d;
    logic [1:0]        count_q, count_d;

    // Next-state: keep the oldest entry in slot0 so the head needs no mux.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    slot0_d = data;
                end else begin
                    slot1_d = data;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    slot0_d = data;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = data;
                end
            end
            default: ;
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = slot0_q;
    assign empty = (count_q == 2'd0);

endmodule

// File: rtl/bram_rd_streamer.sv
// Reads len consecutive RAM words from base_addr and streams them out on valid/ready.
module bram_rd_streamer
    import bram_pkg::*;
#(
    parameter int unsigned DWIDTH = DefDwidth,
    parameter int unsigned AWIDTH = DefAwidth,
    parameter int unsigned LWIDTH = DefLwidth
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [LWIDTH-1:0] len,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [DWIDTH-1:0] mem_d,
    input  logic [DWIDTH-1:0] mem_q,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data
);

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [LWIDTH-1:0] remaining_q, remaining_d;
    logic              inflight_q;

    logic [1:0]        fifo_count;
    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_head;
    logic              pop;
    logic              drained;

    assign pop     = m_valid & m_ready;
    assign drained = !inflight_q && fifo_empty;

    // State, address and length counters; inflight marks a read whose data lands next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= mem_ce;
        end
    end

    // Next-state: capture the command, count reads out, wait for the pipeline to empty.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = len;
                    state_d     = (len == '0) ? StDrain : StRun;
                end
            end
            StRun: begin
                if (mem_ce) begin
                    addr_d      = addr_q + AWIDTH'(1);
                    remaining_d = remaining_q - LWIDTH'(1);
                end
                if (remaining_d == '0) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (drained) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: a read may issue only if its data is guaranteed a FIFO slot on arrival.
    always_comb begin
        mem_ce = (state_q == StRun) && (remaining_q != '0) &&
                 (((fifo_count + {1'b0, inflight_q}) < 2'(FifoDepth)) || pop);
        busy   = (state_q != StIdle);
        done   = (state_q == StDrain) && drained;
    end

    assign mem_addr = addr_q;
    assign mem_we   = 1'b0;
    assign mem_d    = '0;
    assign m_valid  = !fifo_empty;
    assign m_data   = fifo_head;

    stream_fifo2 #(
        .DWIDTH (DWIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .data  (mem_q),
        .pop   (pop),
        .count (fifo_count),
        .head  (fifo_head),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_bram_rd_streamer.sv
// Scoreboard bench for bram_rd_streamer: reference RAM contents, queued expectations,
// negedge monitor comparing every read address and every stream handshake.
module tb_bram_rd_streamer;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start     = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] len       = '0;
    logic          busy, done, mem_ce, mem_we, m_valid;
    logic          m_ready   = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_d, m_data;
    logic [DW-1:0] mem_q     = '0;

    // Narrow-address instance for wraparound.
    logic          start4 = 1'b0;
    logic [3:0]    base4  = '0;
    logic [LW-1:0] len4   = '0;
    logic          busy4, done4, ce4, we4, valid4;
    logic          ready4 = 1'b1;
    logic [3:0]    addr4;
    logic [DW-1:0] d4, data4;
    logic [DW-1:0] q4     = '0;

    bram_rd_streamer #(.DWIDTH(DW), .AWIDTH(AW), .LWIDTH(LW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we),
        .mem_d(mem_d), .mem_q(mem_q), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    bram_rd_streamer #(.DWIDTH(DW), .AWIDTH(4), .LWIDTH(LW)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .base_addr(base4), .len(len4),
        .busy(busy4), .done(done4), .mem_addr(addr4), .mem_ce(ce4), .mem_we(we4),
        .mem_d(d4), .mem_q(q4), .m_valid(valid4), .m_ready(ready4), .m_data(data4)
    );

    // RAM contents as a pure function of address.
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA500_0000 ^ {a[15:0], a[15:0]};
    endfunction

    // Registered-output RAM models with one-cycle read latency.
    always @(posedge clk) if (mem_ce) mem_q <= ram_word(mem_addr);
    always @(posedge clk) if (ce4) q4 <= ram_word({28'd0, addr4});

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Scoreboard state.
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    int issued = 0, popped = 0, done_cnt = 0;
    int done_cyc = -1, last_pop_cyc = -1, first_ce_cyc = -1, last_ce_cyc = -1;
    int first_valid_cyc = -1;
    bit stall_prev = 1'b0;
    logic [DW-1:0] held = '0;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;

    // Monitor: compares reads and handshakes against the queued expectations.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
            issued     = 0;
            popped     = 0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", m_data, held);
            end
            if (issued - popped > 2) chk("fifo_bound", 32'(issued - popped), 32'd2);
            if (mem_ce) begin
                if (exp_addr.size() == 0) begin
                    chk("unexpected_read", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    ea = exp_addr.pop_front();
                    chk("mem_addr", mem_addr, ea);
                end
                chk("mem_we_d", {31'd0, mem_we} | mem_d, 32'd0);
                if (first_ce_cyc < 0) first_ce_cyc = cyc;
                last_ce_cyc = cyc;
                issued++;
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid && m_ready) begin
                if (exp_data.size() == 0) begin
                    chk("unexpected_word", m_data, 32'hFFFF_FFFF);
                end else begin
                    ed = exp_data.pop_front();
                    chk("m_data", m_data, ed);
                end
                last_pop_cyc = cyc;
                popped++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            stall_prev = m_valid && !m_ready;
            held       = m_data;
        end
    end

    // Narrow-instance log.
    logic [3:0]    addr4_log[$];
    logic [DW-1:0] data4_log[$];
    int done4_cnt = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (ce4) addr4_log.push_back(addr4);
            if (valid4 && ready4) data4_log.push_back(data4);
            if (done4) done4_cnt++;
        end
    end

    // Consumer: always ready, or random with occasional 5-cycle stalls.
    int rdy_mode = 0;
    int low_run  = 0;
    int unsigned r;
    always begin
        @(posedge clk);
        #1;
        if (rdy_mode == 0) begin
            m_ready = 1'b1;
        end else if (low_run > 0) begin
            m_ready = 1'b0;
            low_run--;
        end else begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                m_ready = 1'b0;
                low_run = 4;
            end else begin
                m_ready = (r > 4);
            end
        end
    end

    int start_cyc = 0;
    int issued0   = 0;

    // Accepted command: queue the expected reads and words, then strobe start for one edge.
    task automatic start_xfer(input logic [AW-1:0] b, input logic [LW-1:0] l);
        first_ce_cyc    = -1;
        first_valid_cyc = -1;
        issued0         = issued;
        for (int i = 0; i < int'(l); i++) begin
            exp_addr.push_back(b + AW'(i));
            exp_data.push_back(ram_word(b + AW'(i)));
        end
        start     = 1'b1;
        base_addr = b;
        len       = l;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget);
        int n0 = done_cnt;
        int k  = 0;
        while (done_cnt == n0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("done_seen", 32'(done_cnt != n0), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("done_once", 32'(done_cnt - n0), 32'd1);
        chk("words_left", 32'(exp_data.size()), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_mem_ce"}, 32'(mem_ce), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_data"}, m_data, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [LW-1:0] l;
        logic [3:0] wa;

        // Reset values.
        #12;
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic: full-rate stream with exact latency.
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        start_xfer(32'h10, 16'd4);
        chk("basic_busy", 32'(busy), 32'd1);
        wait_done(100);
        chk("basic_first_ce", 32'(first_ce_cyc), 32'(start_cyc));
        chk("basic_last_ce", 32'(last_ce_cyc), 32'(start_cyc + 3));
        chk("basic_first_valid", 32'(first_valid_cyc), 32'(start_cyc + 2));
        chk("basic_last_pop", 32'(last_pop_cyc), 32'(start_cyc + 5));
        chk("basic_done_cyc", 32'(done_cyc), 32'(start_cyc + 6));
        chk("basic_reads", 32'(issued - issued0), 32'd4);

        // Backpressure with random lengths and addresses.
        rdy_mode = 1;
        for (int t = 0; t < 6; t++) begin
            l = (t == 0) ? 16'd8 : 16'($urandom_range(1, 12));
            start_xfer(32'($urandom), l);
            wait_done(600);
            chk("bp_done_after_last", 32'(done_cyc), 32'(last_pop_cyc + 1));
            chk("bp_reads", 32'(issued - issued0), 32'(l));
        end

        // Zero length.
        start_xfer(32'h40, 16'd0);
        wait_done(20);
        chk("zero_done_cyc", 32'(done_cyc), 32'(start_cyc));
        chk("zero_reads", 32'(issued - issued0), 32'd0);
        chk("zero_no_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);

        // Start while busy is ignored.
        start_xfer(32'h100, 16'd10);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_mid", 32'(busy), 32'd1);
        start     = 1'b1;
        base_addr = 32'h200;
        len       = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(800);
        chk("busy_start_reads", 32'(issued - issued0), 32'd10);

        // Reset mid-transfer after three words.
        start_xfer(32'h300, 16'd8);
        n = 0;
        while (popped - issued0 < 3 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reset_mid_reach3", 32'(popped - issued0 >= 3), 32'd1);
        n = done_cnt;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        exp_addr.delete();
        exp_data.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midreset_no_done", 32'(done_cnt), 32'(n));
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        start_xfer(32'h20, 16'd2);
        wait_done(50);
        chk("post_reset_reads", 32'(issued - issued0), 32'd2);

        // Address wraparound on a 4-bit address port.
        addr4_log.delete();
        data4_log.delete();
        n      = done4_cnt;
        base4  = 4'hE;
        len4   = 16'd4;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        for (int k = 0; k < 50 && done4_cnt == n; k++) begin
            @(posedge clk);
            #1;
        end
        chk("wrap_done", 32'(done4_cnt - n), 32'd1);
        chk("wrap_reads", 32'(addr4_log.size()), 32'd4);
        chk("wrap_words", 32'(data4_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            wa = 4'hE + 4'(i);
            if (i < addr4_log.size()) chk("wrap_addr", 32'(addr4_log[i]), 32'(wa));
            if (i < data4_log.size()) chk("wrap_data", data4_log[i], ram_word({28'd0, wa}));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_rd_streamer.md
Name: bram_rd_streamer

Overview:
- Read-side initiator for the team's dual-port block RAM. It drives one RAM port (addr/ce/we/d, with registered q and 1-cycle read latency).
- On a start command, reads `len` consecutive words from `base_addr` and emits them in order on a valid/ready stream.
- Tolerates arbitrary consumer backpressure without losing or duplicating words.
- Feeds the accelerator datapaths from weight/activation buffers.

Parameters:
- DWIDTH, 32, data word width; matches the RAM.
- AWIDTH, 32, RAM address width.
- LWIDTH, 16, transfer length counter width; max transfer is 2^LWIDTH-1 words.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  AWIDTH  first word address; captured with start.
- len  in  LWIDTH  word count; captured with start.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse when the transfer completes.
- mem_addr  out  AWIDTH  RAM port address.
- mem_ce  out  1  RAM port enable; one read per asserted cycle.
- mem_we  out  1  tied 0.
- mem_d  out  DWIDTH  tied 0.
- mem_q  in  DWIDTH  RAM read data; valid the cycle after mem_ce.
- m_valid  out  1  stream data valid.
- m_ready  in  1  consumer ready.
- m_data  out  DWIDTH  stream data.

Behaviour:
- Reset (async assert, sync deassert use): busy=0, done=0, mem_ce=0, mem_addr=0, m_valid=0, m_data=0. The FIFO is empty, the inflight flag is 0, and state is IDLE. Reset mid-transfer aborts it; no done pulse; in-flight data is discarded.
- States: IDLE, RUN, DRAIN.
  - IDLE: on start=1, latch base_addr into the address counter and len into the remaining counter, then go to RUN. If len=0, go to DRAIN instead: no reads, done pulses in the next cycle.
  - RUN: issue reads while remaining>0. Go to DRAIN in the cycle after the last read issues.
  - DRAIN: wait until inflight=0 and the FIFO is empty, then pulse done, drop busy, and return to IDLE.
- start while busy is ignored. start and the done cycle coinciding: start is ignored, because state is not yet IDLE.
- Read issue rule in RUN: mem_ce=1 iff remaining>0 and (fifo_count + inflight < 2, or a stream pop occurs this cycle, i.e. m_valid & m_ready).
  - mem_ce is combinational from registered state.
  - mem_addr = address counter, incremented by 1 per issued read, wrapping modulo 2^AWIDTH.
- inflight <= mem_ce each cycle. When inflight=1, mem_q is pushed into the 2-entry FIFO at the clock edge.
  - The issue rule guarantees the push never overflows.
- Stream output: m_valid = FIFO non-empty; m_data = FIFO head. Data is held stable while m_valid & !m_ready.
- Simultaneous push and pop on the FIFO is legal at any occupancy from 1 to 2.
- Latency: start accepted at edge E0 → first mem_ce in cycle after E0 → first m_valid after E2 (3 cycles).
- Throughput: one word per cycle with m_ready held high.
- done: asserted in the cycle after the edge at which the final word's handshake completes. busy falls in the same cycle.

Decomposition:
- Package bram_pkg: state enum (IDLE/RUN/DRAIN), default DWIDTH/AWIDTH/LWIDTH constants, FIFO depth constant (2).
- One sub-module: stream_fifo2, a 2-entry synchronous FIFO.
  - Inputs: push/data.
  - Outputs: count, head, empty.
  - Input: pop.
  - Same-cycle push+pop supported.

Test Plan:
- Basic: base_addr=0x10, len=4, RAM[0x10..0x13]=A0..A3, m_ready=1 → mem_ce on 4 consecutive cycles, addr 0x10..0x13. m_data A0..A3 on 4 consecutive cycles starting 3 cycles after start. done pulses once; busy low afterwards.
- Backpressure: len=8, m_ready toggled randomly (including 5-cycle low stretches) → exactly 8 words in order, m_data stable while stalled, FIFO never overflows, no re-read of any address.
- Zero length: len=0 → no mem_ce, no m_valid, done pulses in the cycle after start acceptance.
- Wrap: AWIDTH=4, base_addr=0xE, len=4 → addresses 0xE, 0xF, 0x0, 0x1.
- Start while busy: second start mid-transfer with different base/len → ignored; original transfer completes unchanged.
- Reset mid-operation: rst_n low after 3 of 8 words → all outputs at reset values immediately. A new transfer after release (base 0x20, len 2) completes correctly with no stale data.
